// File: rtl/zq_cal_pkg.sv
// Shared types and defaults for the ZQ calibration sequencer.
// The state encoding, code width and power-on code are used by the controller and its interface.
package zq_cal_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int                    CODE_W_DEF     = 7;
    localparam logic [CODE_W_DEF-1:0] RESET_CODE_DEF = 7'd64;

endpackage

// File: rtl/zq_cal_ctrl_if.sv
// Bundle between the ZQ calibration controller and its CSR/PHY neighbours.
// The master side is the controller; the slave side is the CSR block and phy_backend.
interface zq_cal_ctrl_if
    import zq_cal_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF
);

    logic              start_i;
    logic              comparator_i;
    logic [CODE_W-1:0] zq_config_o;
    logic              zq_cal_en_o;
    logic              busy_o;
    logic              done_o;
    logic              valid_o;
    logic [CODE_W-1:0] result_o;

    modport master (
        input  start_i,
        input  comparator_i,
        output zq_config_o,
        output zq_cal_en_o,
        output busy_o,
        output done_o,
        output valid_o,
        output result_o
    );

    modport slave (
        output start_i,
        output comparator_i,
        input  zq_config_o,
        input  zq_cal_en_o,
        input  busy_o,
        input  done_o,
        input  valid_o,
        input  result_o
    );

endinterface

// File: rtl/zq_cal_ctrl.sv
// Successive-approximation ZQ calibration sequencer with optional periodic recalibration.
// Each code bit is tried for SETTLE_CYCLES+1 cycles and the comparator is sampled on the last one.
//
// state  | meaning
// IDLE   | code parked on last result (or RESET_CODE); waiting for start or timer expiry
// SEARCH | trial code driven, comparator enabled, settle then sample one bit
// DONE   | one-cycle result publish, done_o pulse
module zq_cal_ctrl
    import zq_cal_pkg::*;
#(
    parameter int                CODE_W        = CODE_W_DEF,
    parameter int                SETTLE_CYCLES = 4,
    parameter logic [CODE_W-1:0] RESET_CODE    = CODE_W'(RESET_CODE_DEF),
    parameter int                RECAL_PERIOD  = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    zq_cal_ctrl_if.master bus
);

    localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = (RECAL_PERIOD > 0) ? $clog2(RECAL_PERIOD + 1) : 1;

    localparam logic [CODE_W-1:0] ONE_CODE = CODE_W'(1);
    localparam logic [CODE_W-1:0] TOP_BIT  = ONE_CODE << (CODE_W - 1);

    state_t            r_state;
    logic [CODE_W-1:0] r_work;
    logic [BIT_W-1:0]  r_bit;
    logic [CNT_W-1:0]  r_cnt;
    logic [CODE_W-1:0] r_zq_config;
    logic              r_cal_en;
    logic              r_busy;
    logic              r_done;
    logic              r_valid;
    logic [CODE_W-1:0] r_result;

    logic [CODE_W-1:0] w_trial_mask;
    logic [CODE_W-1:0] w_next_mask;
    logic [CODE_W-1:0] w_work_next;
    logic              w_tmr_expired;
    logic              w_trigger;

    assign w_trial_mask = ONE_CODE << r_bit;
    assign w_next_mask  = ONE_CODE << (r_bit - BIT_W'(1));
    // Comparator low means the trial code is not above the target, so the bit is kept.
    assign w_work_next  = bus.comparator_i ? r_work : (r_work | w_trial_mask);
    assign w_trigger    = bus.start_i | w_tmr_expired;

    generate
        if (RECAL_PERIOD > 0) begin : g_recal
            logic [TMR_W-1:0] r_tmr;

            assign w_tmr_expired = (r_state == IDLE) && r_valid &&
                                   (r_tmr == TMR_W'(RECAL_PERIOD));

            // Runs only while parked on a valid result; any other state restarts it at zero.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_tmr <= '0;
                end else if ((r_state == IDLE) && r_valid) begin
                    if (!w_tmr_expired) begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end else begin
                    r_tmr <= '0;
                end
            end
        end else begin : g_no_recal
            assign w_tmr_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_bit       <= '0;
            r_cnt       <= '0;
            r_zq_config <= RESET_CODE;
            r_cal_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_result    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cal_en    <= 1'b0;
                    r_busy      <= 1'b0;
                    r_zq_config <= r_valid ? r_result : RESET_CODE;
                    if (w_trigger) begin
                        r_work      <= '0;
                        r_bit       <= BIT_W'(CODE_W - 1);
                        r_cnt       <= CNT_W'(SETTLE_CYCLES);
                        r_zq_config <= TOP_BIT;
                        r_cal_en    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= SEARCH;
                    end
                end

                SEARCH: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_work <= w_work_next;
                        if (r_bit != '0) begin
                            r_bit       <= r_bit - BIT_W'(1);
                            r_cnt       <= CNT_W'(SETTLE_CYCLES);
                            r_zq_config <= w_work_next | w_next_mask;
                        end else begin
                            r_zq_config <= w_work_next;
                            r_result    <= w_work_next;
                            r_valid     <= 1'b1;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cal_en    <= 1'b0;
                            r_state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    r_zq_config <= r_result;
                    r_state     <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.zq_config_o = r_zq_config;
    assign bus.zq_cal_en_o = r_cal_en;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.valid_o     = r_valid;
    assign bus.result_o    = r_result;

endmodule
